// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue sequencer sitting in front of the 16-bit alu.
// Takes one instruction at a time over valid/ready and reads both operands
// from an internal register file. It drives the alu for one cycle, then
// writes the result back. A side load port preloads registers at any time.
// Optional feature: define FLAGS_EN to add the flag_z / flag_n result flags.
module alu_issue_ctrl #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [1:0]               instr_op,
    input  logic [$clog2(NREG)-1:0]  instr_rs1,
    input  logic [$clog2(NREG)-1:0]  instr_rs2,
    input  logic [$clog2(NREG)-1:0]  instr_rd,
    input  logic                     ld_valid,
    input  logic [$clog2(NREG)-1:0]  ld_addr,
    input  logic [DW-1:0]            ld_data,
    output logic [DW-1:0]            alu_A,
    output logic [DW-1:0]            alu_B,
    output logic [1:0]               alu_op,
    input  logic [DW-1:0]            alu_R,
    output logic                     wb_valid,
    output logic [$clog2(NREG)-1:0]  wb_rd,
    output logic [DW-1:0]            wb_data,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DW-1:0]            dbg_data
`ifdef FLAGS_EN
    ,
    output logic                     flag_z,
    output logic                     flag_n
`endif
);

    localparam int AW = $clog2(NREG);
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   regfile [NREG];
    logic [DW-1:0]   res;
    logic [AW-1:0]   rd_q;

    assign wb_rd    = rd_q;
    assign wb_data  = res;
    assign dbg_data = regfile[dbg_addr];

    // Sequencer: operands go straight into the alu input registers on accept,
    // so they are stable for the whole EXEC cycle and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op      <= 2'd0;
            rd_q        <= '0;
            res         <= '0;
            wb_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    if (instr_valid && instr_ready) begin
                        alu_A       <= regfile[instr_rs1];
                        alu_B       <= regfile[instr_rs2];
                        alu_op      <= instr_op;
                        rd_q        <= instr_rd;
                        instr_ready <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (alu_op == OP_MUL) begin
                        res <= {{(DW-8){1'b0}}, alu_R[7:0]};
                    end else begin
                        res <= alu_R;
                    end
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    wb_valid    <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    wb_valid    <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Register file: the side load is applied first, so a write-back to the
    // same address on the same edge overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            if (ld_valid) begin
                regfile[ld_addr] <= ld_data;
            end
            if (state == WB) begin
                regfile[rd_q] <= res;
            end
        end
    end

`ifdef FLAGS_EN
    // Result flags follow write-backs only; side loads leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == WB) begin
            flag_z <= (res == '0);
            flag_n <= res[DW-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test of alu_issue_ctrl with a behavioural alu.
// Expected write-backs go into a scoreboard queue, and a negedge monitor
// pops and compares each time wb_valid is seen. Build with FLAGS_EN defined
// to also exercise the result flags.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [2:0]  instr_rd;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [1:0]  alu_op;
    logic [15:0] alu_R;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        int          cyc;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t mon_e;
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      wb_count = 0;
    int      wb_before;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_rd    (instr_rd),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_op      (alu_op),
        .alu_R       (alu_R),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef FLAGS_EN
        ,
        .flag_z      (flag_z),
        .flag_n      (flag_n)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural alu; MUL deliberately leaves the high product byte on the
    // bus so the controller's masking is exercised.
    always_comb begin
        alu_R = 16'h0000;
        case (alu_op)
            2'd0: alu_R = alu_A ^ alu_B;
            2'd1: alu_R = alu_A + alu_B;
            2'd2: alu_R = 16'(alu_A[7:0]) * 16'(alu_B[7:0]);
            2'd3: alu_R = alu_A - alu_B;
            default: alu_R = 16'h0000;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write-back pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            wb_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wb_unexpected: got wb_valid=1 (rd=%0d data=0x%0h) expected no write-back", wb_rd, wb_data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                checkOutput("wb_data", 32'(wb_data), 32'(mon_e.data));
                checkOutput("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic load_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(posedge clk);
        #1 ld_valid = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        checkOutput(name, 32'(dbg_data), 32'(exp));
    endtask

    task automatic check_flags(input logic z, input logic n);
`ifdef FLAGS_EN
        checkOutput("flag_z", 32'(flag_z), 32'(z));
        checkOutput("flag_n", 32'(flag_n), 32'(n));
`else
        if (z === 1'bz && n === 1'bz) $display("[TB] flags not built");
`endif
    endtask

    // One instruction; ld_when selects a side load on the accept (0), EXEC (1)
    // or WB (2) edge, -1 for none. rst_in_exec aborts it with a reset pulse.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                                 input logic [2:0] rd, input logic [15:0] exp_a, input logic [15:0] exp_b,
                                 input logic [15:0] exp_r, input int ld_when, input logic [2:0] la,
                                 input logic [15:0] ld, input bit rst_in_exec);
        @(negedge clk);
        checkOutput("ready_idle", 32'(instr_ready), 32'd1);
        instr_op    = op;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_rd    = rd;
        instr_valid = 1'b1;
        if (ld_when == 0) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ld;
        end
        if (!rst_in_exec) sb.push_back('{rd, exp_r, cyc + 2});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        ld_valid = 1'b0;
        @(negedge clk);
        checkOutput("alu_A", 32'(alu_A), 32'(exp_a));
        checkOutput("alu_B", 32'(alu_B), 32'(exp_b));
        checkOutput("alu_op", 32'(alu_op), 32'(op));
        checkOutput("ready_exec", 32'(instr_ready), 32'd0);
        if (rst_in_exec) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        if (ld_when == 1) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ld;
        end
        @(posedge clk);
        #1 ld_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_wb", 32'(instr_ready), 32'd0);
        if (ld_when == 2) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ld;
        end
        @(posedge clk);
        #1 ld_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0; instr_op = 2'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_rd = 3'd0;
        ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; dbg_addr = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rst_ready", 32'(instr_ready), 32'd1);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_data", 32'(wb_data), 32'd0);
        checkOutput("rst_alu_A", 32'(alu_A), 32'd0);
        checkOutput("rst_alu_B", 32'(alu_B), 32'd0);
        checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
        check_flags(1'b0, 1'b0);

        // Reset mid-EXEC abandons the instruction and clears the regfile
        load_reg(3'd1, 16'h1111);
        load_reg(3'd2, 16'h2222);
        wb_before = wb_count;
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd3, 16'h1111, 16'h2222, 16'h0, -1, 3'd0, 16'h0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_wb", 32'(wb_count), 32'(wb_before));
        checkOutput("rst_mid_ready", 32'(instr_ready), 32'd1);
        checkOutput("rst_mid_alu_A", 32'(alu_A), 32'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 16'h0000);

        // XOR
        load_reg(3'd1, 16'h00F0);
        load_reg(3'd2, 16'h0F0F);
        applyStimulus(2'd0, 3'd1, 3'd2, 3'd3, 16'h00F0, 16'h0F0F, 16'h0FFF, -1, 3'd0, 16'h0, 1'b0);
        check_reg("xor_r3", 3'd3, 16'h0FFF);

        // ADD wraps
        load_reg(3'd1, 16'hFFFF);
        load_reg(3'd2, 16'h0002);
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd4, 16'hFFFF, 16'h0002, 16'h0001, -1, 3'd0, 16'h0, 1'b0);
        check_reg("add_r4", 3'd4, 16'h0001);
        check_flags(1'b0, 1'b0);

        // SUB going negative: 0 - 2
        applyStimulus(2'd3, 3'd0, 3'd2, 3'd7, 16'h0000, 16'h0002, 16'hFFFE, -1, 3'd0, 16'h0, 1'b0);
        check_reg("sub_r7", 3'd7, 16'hFFFE);
        check_flags(1'b0, 1'b1);

        // rs1 == rs2, XOR gives zero into r4
        applyStimulus(2'd0, 3'd2, 3'd2, 3'd4, 16'h0002, 16'h0002, 16'h0000, -1, 3'd0, 16'h0, 1'b0);
        check_reg("xor_self_r4", 3'd4, 16'h0000);
        check_flags(1'b1, 1'b0);

        // MUL keeps only the low byte
        load_reg(3'd1, 16'h0012);
        load_reg(3'd2, 16'h0034);
        applyStimulus(2'd2, 3'd1, 3'd2, 3'd5, 16'h0012, 16'h0034, 16'h00A8, -1, 3'd0, 16'h0, 1'b0);
        check_reg("mul_r5", 3'd5, 16'h00A8);
        load_reg(3'd1, 16'hAB12);
        applyStimulus(2'd2, 3'd1, 3'd2, 3'd5, 16'hAB12, 16'h0034, 16'h00A8, -1, 3'd0, 16'h0, 1'b0);
        check_reg("mul_hi_r5", 3'd5, 16'h00A8);

        // Load on WB edge to rd: write-back wins
        load_reg(3'd1, 16'h0010);
        load_reg(3'd2, 16'h0020);
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd6, 16'h0010, 16'h0020, 16'h0030, 2, 3'd6, 16'h1234, 1'b0);
        check_reg("wb_wins_r6", 3'd6, 16'h0030);

        // Load on WB edge to another register: both land
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd3, 16'h0010, 16'h0020, 16'h0030, 2, 3'd7, 16'h5555, 1'b0);
        check_reg("both_r3", 3'd3, 16'h0030);
        check_reg("both_r7", 3'd7, 16'h5555);

        // Load on accept edge to rs1: operand uses the old value
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd5, 16'h0010, 16'h0020, 16'h0030, 0, 3'd1, 16'h0100, 1'b0);
        check_reg("nobypass_r5", 3'd5, 16'h0030);
        check_reg("nobypass_r1", 3'd1, 16'h0100);

        // Load to rd during EXEC gets overwritten by write-back
        applyStimulus(2'd1, 3'd1, 3'd2, 3'd6, 16'h0100, 16'h0020, 16'h0120, 1, 3'd6, 16'hBEEF, 1'b0);
        check_reg("exec_ld_r6", 3'd6, 16'h0120);

        // rd equals both sources
        applyStimulus(2'd1, 3'd2, 3'd2, 3'd2, 16'h0020, 16'h0020, 16'h0040, -1, 3'd0, 16'h0, 1'b0);
        check_reg("rd_src_r2", 3'd2, 16'h0040);

        // Continuous instr_valid: ready 1,0,0 repeating, one write-back per 3 cycles
        wb_before = wb_count;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checkOutput("ready_pattern", 32'(instr_ready), 32'(i % 3 == 0));
            if (i == 0) begin
                instr_op = 2'd1; instr_rs1 = 3'd2; instr_rs2 = 3'd2; instr_rd = 3'd3;
                instr_valid = 1'b1;
            end
            if (i % 3 == 0) sb.push_back('{3'd3, 16'h0080, cyc + 2});
        end
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stream_wb_count", 32'(wb_count - wb_before), 32'd3);
        check_reg("stream_r3", 3'd3, 16'h0080);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
